// File: rtl/hex_scan_pkg.sv
// Shared types and helpers for the multiplexed hex digit scanner.
package hex_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int MAX_DIGITS = 8;

  // Widest possible dark anode pattern; callers truncate it to their digit count.
  function automatic logic [MAX_DIGITS-1:0] ANODE_OFF();
    return '1;
  endfunction

  function automatic int idxWidth(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/hex_digit_scanner_prescaler.sv
// Digit-slot prescaler: counts 0..CLK_DIV-1 and pulses o_tick on the last count.
module scan_prescaler #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_count;

  // With CLK_DIV=1 the count stays at 0 and the tick fires every running cycle.
  assign o_tick = !i_restart && (r_count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_restart || o_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/hex_digit_scanner.sv
// Time-multiplexes a DIGITS-nibble hex word onto one digit lane with active-low anodes.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module hex_digit_scanner
  import hex_scan_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 50000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          load,
  input  logic [4*DIGITS-1:0]           data,
  output logic                          ready,
  output logic [3:0]                    digit_data,
  output logic                          digit_start,
  output logic [DIGITS-1:0]             anode,
  output logic [idxWidth(DIGITS)-1:0]   digit_idx
);

  localparam int IW = idxWidth(DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ANODE_DARK = DIGITS'(ANODE_OFF());

  state_t              r_state, w_stateNext;
  logic [4*DIGITS-1:0] r_active, w_activeNext;
  logic [4*DIGITS-1:0] r_pending, w_pendingNext;
  logic                r_pendValid, w_pendValidNext;
  logic [IW-1:0]       r_idx, w_idxNext;
  logic [DIGITS-1:0]   r_anode, w_anodeNext;
  logic [3:0]          r_data, w_dataNext;
  logic                r_start, w_startNext;

  logic                w_tick, w_restart, w_accept, w_frameEnd, w_lit, w_blank;
  logic [IW-1:0]       w_showIdx;
  logic [4*DIGITS-1:0] w_showWord;

  assign w_restart = (r_state != SCAN) || clear;

  scan_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // Next-state logic; output registers are computed from the digit about to be shown.
  always_comb begin
    w_stateNext     = r_state;
    w_activeNext    = r_active;
    w_pendingNext   = r_pending;
    w_pendValidNext = r_pendValid;
    w_showIdx       = r_idx;
    w_showWord      = r_active;
    w_lit           = 1'b0;
    w_accept        = load && !r_pendValid && !clear;
    w_frameEnd      = w_tick && (r_idx == LAST_IDX);

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_stateNext  = SCAN;
          w_activeNext = data;
          w_showIdx    = '0;
          w_showWord   = data;
          w_lit        = 1'b1;
        end
      end
      SCAN: begin
        w_lit = 1'b1;
        if (w_tick) begin
          w_showIdx = w_frameEnd ? '0 : r_idx + 1'b1;
        end
        if (w_frameEnd && r_pendValid) begin
          w_activeNext    = r_pending;
          w_pendValidNext = 1'b0;
          w_showWord      = r_pending;
        end
        // Mutually exclusive with the commit above: accept needs pending empty.
        if (w_accept) begin
          w_pendingNext   = data;
          w_pendValidNext = 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase

    if (clear) begin
      w_stateNext     = IDLE;
      w_activeNext    = '0;
      w_pendValidNext = 1'b0;
      w_showIdx       = '0;
      w_lit           = 1'b0;
    end

`ifdef LEADING_ZERO_BLANK_EN
    w_blank = (w_showIdx != '0) && ((w_showWord >> (4 * w_showIdx)) == '0);
`else
    w_blank = 1'b0;
`endif

    w_idxNext   = w_lit ? w_showIdx : '0;
    w_dataNext  = w_lit ? w_showWord[4*w_showIdx +: 4] : 4'h0;
    w_startNext = w_lit && !w_blank;
    w_anodeNext = ANODE_DARK;
    if (w_lit && !w_blank) begin
      w_anodeNext[w_showIdx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_active    <= '0;
      r_pending   <= '0;
      r_pendValid <= 1'b0;
      r_idx       <= '0;
      r_anode     <= ANODE_DARK;
      r_data      <= 4'h0;
      r_start     <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_active    <= w_activeNext;
      r_pending   <= w_pendingNext;
      r_pendValid <= w_pendValidNext;
      r_idx       <= w_idxNext;
      r_anode     <= w_anodeNext;
      r_data      <= w_dataNext;
      r_start     <= w_startNext;
    end
  end

  assign ready       = ~r_pendValid;
  assign digit_data  = r_data;
  assign digit_start = r_start;
  assign anode       = r_anode;
  assign digit_idx   = r_idx;

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Directed bench for hex_digit_scanner (DIGITS=4) with a CLK_DIV=4 and a CLK_DIV=1 instance.
module tb_hex_digit_scanner;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

   typedef struct {
      logic [1:0] idx;
      logic [3:0] anode;
      logic [3:0] nib;
      logic       start;
      logic       rdy;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        load = 1'b0;
   logic [15:0] data = 16'h0;
   logic        ready;
   logic [3:0]  digitData;
   logic        digitStart;
   logic [3:0]  anode;
   logic [1:0]  digitIdx;

   logic        clear1 = 1'b0;
   logic        load1 = 1'b0;
   logic [15:0] data1 = 16'h0;
   logic        ready1;
   logic [3:0]  digitData1;
   logic        digitStart1;
   logic [3:0]  anode1;
   logic [1:0]  digitIdx1;

   int testsRun = 0;
   int failCount = 0;
   vec_t frameVecs[6];

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   hex_digit_scanner #(.DIGITS(4), .CLK_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .data(data),
      .ready(ready), .digit_data(digitData), .digit_start(digitStart),
      .anode(anode), .digit_idx(digitIdx)
   );

   hex_digit_scanner #(.DIGITS(4), .CLK_DIV(1)) dutFast (
      .clk(clk), .rst_n(rst_n), .clear(clear1), .load(load1), .data(data1),
      .ready(ready1), .digit_data(digitData1), .digit_start(digitStart1),
      .anode(anode1), .digit_idx(digitIdx1)
   );

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   task automatic applyStimulus(input logic ld, input logic clr, input logic [15:0] d);
      load  = ld;
      clear = clr;
      data  = d;
   endtask

   task automatic checkOutput(input string name, input vec_t e);
      testsRun++;
      if ({digitIdx, anode, digitData, digitStart, ready} !== {e.idx, e.anode, e.nib, e.start, e.rdy}) begin
         failCount++;
         $display("[TB] FAIL %s: got idx=%0d anode=%h data=%h start=%b ready=%b, expected idx=%0d anode=%h data=%h start=%b ready=%b",
                  name, digitIdx, anode, digitData, digitStart, ready,
                  e.idx, e.anode, e.nib, e.start, e.rdy);
      end
   endtask

   task automatic checkFast(input string name, input vec_t e);
      testsRun++;
      if ({digitIdx1, anode1, digitData1, digitStart1, ready1} !== {e.idx, e.anode, e.nib, e.start, e.rdy}) begin
         failCount++;
         $display("[TB] FAIL %s: got idx=%0d anode=%h data=%h start=%b ready=%b, expected idx=%0d anode=%h data=%h start=%b ready=%b",
                  name, digitIdx1, anode1, digitData1, digitStart1, ready1,
                  e.idx, e.anode, e.nib, e.start, e.rdy);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Main directed sequence; all sampling happens on the falling edge.
   initial begin
      frameVecs[0] = '{2'd0, 4'hE, 4'hF, 1'b1, 1'b1};
      frameVecs[1] = '{2'd1, 4'hD, 4'h3, 1'b1, 1'b1};
      frameVecs[2] = '{2'd2, 4'hB, 4'hA, 1'b1, 1'b1};
      frameVecs[3] = '{2'd3, 4'h7, 4'h1, 1'b1, 1'b1};
      frameVecs[4] = '{2'd0, 4'hE, 4'hF, 1'b1, 1'b1};
      frameVecs[5] = '{2'd1, 4'hD, 4'h3, 1'b1, 1'b1};

      waitCycles(2);
      checkOutput("reset", '{2'd0, 4'hF, 4'h0, 1'b0, 1'b1});
      rst_n = 1'b1;

      applyStimulus(1'b1, 1'b0, 16'h1A3F);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 16'h0);
      for (int i = 0; i < 6; i++) begin
         for (int c = 0; c < 4; c++) begin
            if (i != 0 || c != 0) @(negedge clk);
            checkOutput($sformatf("scan1A3F_slot%0d_cyc%0d", i, c), frameVecs[i]);
         end
      end

      applyStimulus(1'b1, 1'b0, 16'h1234);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 16'h0);
      checkOutput("pendingLoad_readyDrop", '{2'd2, 4'hB, 4'hA, 1'b1, 1'b0});
      waitCycles(3);
      applyStimulus(1'b1, 1'b0, 16'hBEEF);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 16'h0);
      checkOutput("ignoredLoad_oldWord", '{2'd3, 4'h7, 4'h1, 1'b1, 1'b0});
      waitCycles(3);
      checkOutput("beforeWrap", '{2'd3, 4'h7, 4'h1, 1'b1, 1'b0});
      @(negedge clk);
      checkOutput("commitAtWrap", '{2'd0, 4'hE, 4'h4, 1'b1, 1'b1});
      waitCycles(4);
      checkOutput("beefIgnored", '{2'd1, 4'hD, 4'h3, 1'b1, 1'b1});
      waitCycles(8);
      checkOutput("newWordIdx3", '{2'd3, 4'h7, 4'h1, 1'b1, 1'b1});

      waitCycles(3);
      applyStimulus(1'b1, 1'b0, 16'h5678);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 16'h0);
      checkOutput("frameEndLoad_noCommit", '{2'd0, 4'hE, 4'h4, 1'b1, 1'b0});
      waitCycles(4);
      checkOutput("frameEndLoad_stillOld", '{2'd1, 4'hD, 4'h3, 1'b1, 1'b0});
      waitCycles(12);
      checkOutput("frameEndLoad_commit", '{2'd0, 4'hE, 4'h8, 1'b1, 1'b1});

      waitCycles(2);
      applyStimulus(1'b1, 1'b1, 16'h9999);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 16'h0);
      checkOutput("clearPriority", '{2'd0, 4'hF, 4'h0, 1'b0, 1'b1});
      waitCycles(5);
      checkOutput("clearStaysIdle", '{2'd0, 4'hF, 4'h0, 1'b0, 1'b1});

      applyStimulus(1'b1, 1'b0, 16'hABCD);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 16'h0);
      checkOutput("reloadAfterClear", '{2'd0, 4'hE, 4'hD, 1'b1, 1'b1});
      waitCycles(5);
      checkOutput("midFrameBeforeReset", '{2'd1, 4'hD, 4'hC, 1'b1, 1'b1});
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncReset", '{2'd0, 4'hF, 4'h0, 1'b0, 1'b1});
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b0, 16'h0C21);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 16'h0);
      checkOutput("restartAfterReset", '{2'd0, 4'hE, 4'h1, 1'b1, 1'b1});

      applyStimulus(1'b0, 1'b1, 16'h0);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 16'h0050);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 16'h0);
      checkOutput("w0050_d0", '{2'd0, 4'hE, 4'h0, 1'b1, 1'b1});
      waitCycles(4);
      checkOutput("w0050_d1", '{2'd1, 4'hD, 4'h5, 1'b1, 1'b1});
      waitCycles(4);
      checkOutput("w0050_d2", '{2'd2, LZB ? 4'hF : 4'hB, 4'h0, !LZB, 1'b1});
      waitCycles(4);
      checkOutput("w0050_d3", '{2'd3, LZB ? 4'hF : 4'h7, 4'h0, !LZB, 1'b1});

      applyStimulus(1'b0, 1'b1, 16'h0);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 16'h0000);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 16'h0);
      checkOutput("w0000_d0", '{2'd0, 4'hE, 4'h0, 1'b1, 1'b1});
      waitCycles(4);
      checkOutput("w0000_d1", '{2'd1, LZB ? 4'hF : 4'hD, 4'h0, !LZB, 1'b1});

      checkFast("fastIdle", '{2'd0, 4'hF, 4'h0, 1'b0, 1'b1});
      load1 = 1'b1;
      data1 = 16'h4321;
      @(negedge clk);
      load1 = 1'b0;
      data1 = 16'h0;
      checkFast("fast_d0", '{2'd0, 4'hE, 4'h1, 1'b1, 1'b1});
      @(negedge clk);
      checkFast("fast_d1", '{2'd1, 4'hD, 4'h2, 1'b1, 1'b1});
      @(negedge clk);
      checkFast("fast_d2", '{2'd2, 4'hB, 4'h3, 1'b1, 1'b1});
      @(negedge clk);
      checkFast("fast_d3", '{2'd3, 4'h7, 4'h4, 1'b1, 1'b1});
      @(negedge clk);
      checkFast("fast_wrap", '{2'd0, 4'hE, 4'h1, 1'b1, 1'b1});

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
